// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between the write-back requesters and the register-file write arbiter.
// The slave side is the arbiter; the master side is the requester group.
interface regfile_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 64,
    parameter int ADDRW = 5
);
    logic [NREQ-1:0]       req;
    logic [NREQ*ADDRW-1:0] reqAddr;
    logic [NREQ*WIDTH-1:0] reqData;
    logic                  freeze;
    logic [NREQ-1:0]       grant;
    logic                  regWrite;
    logic [ADDRW-1:0]      writeReg;
    logic [WIDTH-1:0]      writeData;
    logic [3:0]            busyCount;

    modport master (
        output req, reqAddr, reqData, freeze,
        input  grant, regWrite, writeReg, writeData, busyCount
    );

    modport slave (
        input  req, reqAddr, reqData, freeze,
        output grant, regWrite, writeReg, writeData, busyCount
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port; registered write outputs.
// Optional macro REGFILE_ARB_ZERO_DROP_EN suppresses regWrite for writes to register 31.
module regfile_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 64,
    parameter int ADDRW = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDRW-1:0] ZERO_REG = ADDRW'(31);

    logic [PTRW-1:0]  ptr_q, ptr_d;
    logic             regWrite_q, regWrite_d;
    logic [ADDRW-1:0] writeReg_q, writeReg_d;
    logic [WIDTH-1:0] writeData_q, writeData_d;
    logic [3:0]       busyCount_q, busyCount_d;

    logic [NREQ-1:0]  grantComb;
    logic [PTRW-1:0]  gIdx;
    logic [PTRW-1:0]  idx;
    logic             anyGrant;
    logic [ADDRW-1:0] addrSel;
    logic [WIDTH-1:0] dataSel;

    // Search starts at ptr and wraps; the first pending requester wins.
    always_comb begin
        grantComb = '0;
        gIdx      = '0;
        idx       = '0;
        anyGrant  = 1'b0;
        if (reset && !bus.freeze) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = PTRW'((int'(ptr_q) + k) % NREQ);
                if (!anyGrant && bus.req[idx]) begin
                    grantComb[idx] = 1'b1;
                    gIdx           = idx;
                    anyGrant       = 1'b1;
                end
            end
        end
    end

    assign addrSel = bus.reqAddr[int'(gIdx)*ADDRW +: ADDRW];
    assign dataSel = bus.reqData[int'(gIdx)*WIDTH +: WIDTH];

    always_comb begin
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        ptr_d       = ptr_q;
        if (anyGrant) begin
`ifdef REGFILE_ARB_ZERO_DROP_EN
            regWrite_d = (addrSel != ZERO_REG);
`else
            regWrite_d = 1'b1;
`endif
            writeReg_d  = addrSel;
            writeData_d = dataSel;
            ptr_d       = (int'(gIdx) == NREQ - 1) ? '0 : gIdx + PTRW'(1);
        end
    end

    // Only a frozen cycle with a pending request can leave a request unserved.
    always_comb begin
        if (anyGrant || !(|bus.req))
            busyCount_d = 4'd0;
        else if (busyCount_q == 4'd15)
            busyCount_d = busyCount_q;
        else
            busyCount_d = busyCount_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q       <= '0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
            busyCount_q <= 4'd0;
        end else begin
            ptr_q       <= ptr_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
            busyCount_q <= busyCount_d;
        end
    end

    assign bus.grant     = grantComb;
    assign bus.regWrite  = regWrite_q;
    assign bus.writeReg  = writeReg_q;
    assign bus.writeData = writeData_q;
    assign bus.busyCount = busyCount_q;
endmodule
